// File: rtl/mul_sum_stage.sv
// Final two-stage adder for the multiplier: folds the two 64-bit partial sums and returns the low or high product word.
// Optional macro MUL_STAT_EN adds the mul_cnt completed-operation counter port.
module mul_sum_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mul_in_valid,
    output logic        mul_in_ready,
    input  logic [63:0] mul_tmp1,
    input  logic [63:0] mul_tmp2,
    input  logic [1:0]  mul_op,
    input  logic [4:0]  mul_tag,
    input  logic        mul_flush,
    output logic        mul_out_valid,
    input  logic        mul_out_ready,
    output logic [31:0] mul_result,
    output logic [4:0]  mul_out_tag
`ifdef MUL_STAT_EN
    ,
    output logic [31:0] mul_cnt
`endif
);

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_lo_q, s1_lo_d;
    logic        s1_carry_q, s1_carry_d;
    logic [31:0] s1_hi1_q, s1_hi1_d;
    logic [31:0] s1_hi2_q, s1_hi2_d;
    logic        s1_hi_sel_q, s1_hi_sel_d;
    logic [4:0]  s1_tag_q, s1_tag_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_lo_q, s2_lo_d;
    logic [31:0] s2_hi_q, s2_hi_d;
    logic        s2_hi_sel_q, s2_hi_sel_d;
    logic [4:0]  s2_tag_q, s2_tag_d;

    logic        s1_adv;
    logic        s2_adv;
    logic        accept;
    logic [32:0] lo_sum;

    assign s2_adv       = !s2_valid_q || mul_out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign mul_in_ready = s1_adv;
    assign accept       = mul_in_valid && mul_in_ready;
    assign lo_sum       = {1'b0, mul_tmp1[31:0]} + {1'b0, mul_tmp2[31:0]};

    // Flush only kills the valid bits; stale data behind a cleared valid is harmless.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_carry_d  = s1_carry_q;
        s1_hi1_d    = s1_hi1_q;
        s1_hi2_d    = s1_hi2_q;
        s1_hi_sel_d = s1_hi_sel_q;
        s1_tag_d    = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_lo_d     = lo_sum[31:0];
            s1_carry_d  = lo_sum[32];
            s1_hi1_d    = mul_tmp1[63:32];
            s1_hi2_d    = mul_tmp2[63:32];
            s1_hi_sel_d = mul_op[0] ^ mul_op[1];
            s1_tag_d    = mul_tag;
        end
        if (mul_flush) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_lo_d     = s2_lo_q;
        s2_hi_d     = s2_hi_q;
        s2_hi_sel_d = s2_hi_sel_q;
        s2_tag_d    = s2_tag_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_lo_d     = s1_lo_q;
                s2_hi_d     = s1_hi1_q + s1_hi2_q + {31'd0, s1_carry_q};
                s2_hi_sel_d = s1_hi_sel_q;
                s2_tag_d    = s1_tag_q;
            end
        end
        if (mul_flush) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_carry_q  <= 1'b0;
            s1_hi1_q    <= '0;
            s1_hi2_q    <= '0;
            s1_hi_sel_q <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_lo_q     <= '0;
            s2_hi_q     <= '0;
            s2_hi_sel_q <= 1'b0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_carry_q  <= s1_carry_d;
            s1_hi1_q    <= s1_hi1_d;
            s1_hi2_q    <= s1_hi2_d;
            s1_hi_sel_q <= s1_hi_sel_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_lo_q     <= s2_lo_d;
            s2_hi_q     <= s2_hi_d;
            s2_hi_sel_q <= s2_hi_sel_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    // Output word chosen purely from S2 registers.
    assign mul_out_valid = s2_valid_q;
    assign mul_result    = s2_hi_sel_q ? s2_hi_q : s2_lo_q;
    assign mul_out_tag   = s2_tag_q;

`ifdef MUL_STAT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q && mul_out_ready) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mul_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mul_sum_stage.sv
// Scoreboard bench for mul_sum_stage: expected words are queued at accept and matched as results leave.
module tb_mul_sum_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mul_in_valid;
    logic        mul_in_ready;
    logic [63:0] mul_tmp1;
    logic [63:0] mul_tmp2;
    logic [1:0]  mul_op;
    logic [4:0]  mul_tag;
    logic        mul_flush;
    logic        mul_out_valid;
    logic        mul_out_ready;
    logic [31:0] mul_result;
    logic [4:0]  mul_out_tag;
`ifdef MUL_STAT_EN
    logic [31:0] mul_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    mul_sum_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .mul_in_valid (mul_in_valid),
        .mul_in_ready (mul_in_ready),
        .mul_tmp1     (mul_tmp1),
        .mul_tmp2     (mul_tmp2),
        .mul_op       (mul_op),
        .mul_tag      (mul_tag),
        .mul_flush    (mul_flush),
        .mul_out_valid(mul_out_valid),
        .mul_out_ready(mul_out_ready),
        .mul_result   (mul_result),
        .mul_out_tag  (mul_out_tag)
`ifdef MUL_STAT_EN
        ,
        .mul_cnt      (mul_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        logic [63:0] s;
        s = a + b;
        return (op == 2'b01 || op == 2'b10) ? s[63:32] : s[31:0];
    endfunction

    // Scoreboard: a handshake seen at this negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (rstn && mul_out_valid && mul_out_ready) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got result=%h tag=%0d, required no output", mul_result, mul_out_tag);
            end else begin
                e = exp_q.pop_front();
                if ({mul_out_tag, mul_result} !== e) begin
                    failures++;
                    $display("FAIL scoreboard: got tag=%0d result=%h, required tag=%0d result=%h",
                             mul_out_tag, mul_result, e[36:32], e[31:0]);
                end else begin
                    $display("out tag=%0d result=%h", mul_out_tag, mul_result);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic [4:0] tag);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        mul_in_valid = 1'b1;
        mul_tmp1 = a;
        mul_tmp2 = b;
        mul_op = op;
        mul_tag = tag;
        while (!done) begin
            @(negedge clk);
            if (mul_in_ready) begin
                exp_q.push_back({tag, model(a, b, op)});
                $display("in  tag=%0d a=%h b=%h op=%0d", tag, a, b, op);
                done = 1;
            end else if (++n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
                done = 1;
            end
            tick();
        end
        mul_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        mul_in_valid = 1'b1;
        mul_tmp1 = 64'h1234;
        mul_tmp2 = 64'h1;
        mul_op = 2'b00;
        mul_tag = 5'd9;
        mul_flush = 1'b0;
        mul_out_ready = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({mul_out_valid, mul_result, mul_out_tag} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b result=%h tag=%0d, required all 0",
                     mul_out_valid, mul_result, mul_out_tag);
        end
`ifdef MUL_STAT_EN
        checks++;
        if (mul_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %h, required 0", mul_cnt);
        end
`endif
        mul_in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (mul_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, required 1", mul_in_ready);
        end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_latency();
        mul_out_ready = 1'b1;
        mul_in_valid = 1'b1;
        mul_tmp1 = 64'd15;
        mul_tmp2 = 64'd0;
        mul_op = 2'b00;
        mul_tag = 5'd3;
        @(negedge clk);
        if (mul_in_ready) exp_q.push_back({5'd3, 32'h0000_000F});
        tick();
        mul_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mul_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", mul_out_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({mul_out_valid, mul_result, mul_out_tag} !== {1'b1, 32'h0000_000F, 5'd3}) begin
            failures++;
            $display("FAIL latency_2cyc: got valid=%b result=%h tag=%0d, required valid=1 result=0000000f tag=3",
                     mul_out_valid, mul_result, mul_out_tag);
        end
        tick();
        drain();
        $display("test_latency done");
    endtask

    task automatic test_carry();
        mul_out_ready = 1'b1;
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 2'b01, 5'd4);
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 2'b00, 5'd5);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b10, 5'd6);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 5'd7);
        send(64'h8000_0001_8000_0000, 64'h7FFF_FFFF_8000_0000, 2'b10, 5'd8);
        drain();
        $display("test_carry done");
    endtask

    task automatic test_backpressure();
        logic [63:0] a[4];
        logic [63:0] b[4];
        logic [31:0] held;
        int idx;
        for (int i = 0; i < 4; i++) begin
            a[i] = {$urandom, $urandom};
            b[i] = {$urandom, $urandom};
        end
        idx = 0;
        held = model(a[0], b[0], 2'b01);
        mul_out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            mul_in_valid = 1'b1;
            mul_tmp1 = a[idx];
            mul_tmp2 = b[idx];
            mul_op = 2'b01;
            mul_tag = 5'(10 + idx);
            if (cyc == 1) mul_out_ready = 1'b0;
            if (cyc == 6) mul_out_ready = 1'b1;
            @(negedge clk);
            if (cyc == 2) begin
                checks++;
                if (mul_in_ready !== 1'b0 || idx != 2) begin
                    failures++;
                    $display("FAIL bp_stall: got in_ready=%b after %0d accepts, required in_ready=0 after 2", mul_in_ready, idx);
                end
            end
            if (cyc >= 3 && cyc < 6) begin
                checks++;
                if ({mul_out_valid, mul_result, mul_out_tag} !== {1'b1, held, 5'd10}) begin
                    failures++;
                    $display("FAIL bp_hold: got valid=%b result=%h tag=%0d, required valid=1 result=%h tag=10",
                             mul_out_valid, mul_result, mul_out_tag, held);
                end
            end
            if (mul_in_ready) begin
                exp_q.push_back({5'(10 + idx), model(a[idx], b[idx], 2'b01)});
                $display("in  tag=%0d a=%h b=%h op=1", 10 + idx, a[idx], b[idx]);
                idx++;
            end
            tick();
        end
        mul_in_valid = 1'b0;
        drain();
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        mul_out_ready = 1'b0;
        send(64'd100, 64'd1, 2'b00, 5'd20);
        send(64'd200, 64'd2, 2'b00, 5'd21);
        mul_in_valid = 1'b1;
        mul_tmp1 = 64'd300;
        mul_tmp2 = 64'd3;
        mul_tag = 5'd22;
        mul_flush = 1'b1;
        tick();
        mul_flush = 1'b0;
        mul_in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (mul_out_valid !== 1'b0 || mul_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b, required 0 and 1", mul_out_valid, mul_in_ready);
        end
        mul_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (mul_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_quiet: got out_valid=%b, required 0", mul_out_valid);
            end
        end
        tick();
        // Empty pipe with ready high: only flush priority can drop this input.
        mul_in_valid = 1'b1;
        mul_tag = 5'd23;
        mul_flush = 1'b1;
        tick();
        mul_flush = 1'b0;
        mul_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mul_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_drop_input: got out_valid=%b, required 0", mul_out_valid);
            end
            tick();
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        mul_out_ready = 1'b1;
        mul_in_valid = 1'b1;
        mul_tmp1 = 64'h55;
        mul_tmp2 = 64'h1;
        mul_op = 2'b00;
        mul_tag = 5'd30;
        tick();
        mul_in_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (mul_out_valid !== 1'b0 || mul_in_ready !== 1'b1 || mul_result !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: got out_valid=%b in_ready=%b result=%h, required 0 1 0",
                     mul_out_valid, mul_in_ready, mul_result);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mul_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got out_valid=%b, required 0", mul_out_valid);
        end
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        mul_out_ready = 1'b1;
        mul_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            op = 2'($urandom_range(0, 3));
            mul_tmp1 = a;
            mul_tmp2 = b;
            mul_op = op;
            mul_tag = 5'(i);
            @(negedge clk);
            checks++;
            if (mul_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready: got in_ready=%b at op %0d, required 1", mul_in_ready, i);
            end else begin
                exp_q.push_back({5'(i), model(a, b, op)});
                $display("in  tag=%0d a=%h b=%h op=%0d", i, a, b, op);
            end
            if (i >= 2) begin
                checks++;
                if (mul_out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_bubble: got out_valid=%b at op %0d, required 1", mul_out_valid, i);
                end
            end
            tick();
        end
        mul_in_valid = 1'b0;
        drain();
        $display("test_back_to_back done");
    endtask

`ifdef MUL_STAT_EN
    task automatic test_stat();
        do_reset();
        mul_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(64'(i), 64'd7, 2'b00, 5'(i));
        drain();
        mul_out_ready = 1'b0;
        send(64'd1, 64'd1, 2'b00, 5'd1);
        send(64'd2, 64'd2, 2'b00, 5'd2);
        mul_flush = 1'b1;
        tick();
        mul_flush = 1'b0;
        exp_q.delete();
        mul_out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (mul_cnt !== 32'd5) begin
            failures++;
            $display("FAIL stat_count: got %0d, required 5", mul_cnt);
        end
        dut.cnt_q = 32'hFFFF_FFFF;
        tick();
        send(64'd9, 64'd9, 2'b00, 5'd9);
        drain();
        @(negedge clk);
        checks++;
        if (mul_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stat_wrap: got %h, required 0", mul_cnt);
        end
        tick();
        $display("test_stat done");
    endtask
`endif

    initial begin
        rstn = 1'b0;
        mul_in_valid = 1'b0;
        mul_tmp1 = '0;
        mul_tmp2 = '0;
        mul_op = '0;
        mul_tag = '0;
        mul_flush = 1'b0;
        mul_out_ready = 1'b0;
        tick();
        test_reset();
        test_latency();
        test_carry();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
`ifdef MUL_STAT_EN
        test_stat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_sum_stage.md
MUL_SUM_STAGE -- requirements
Module: mul_sum_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with the ports named as in the codebase (clk, rstn).
REQ-002 The block SHALL have the following ports, in the order listed:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous active-low reset.
- mul_in_valid  input  1  tmp pair and op are valid this cycle.
- mul_in_ready  output  1  block accepts input this cycle.
- mul_tmp1  input  64  first compressed partial sum from the Booth/CSA tree.
- mul_tmp2  input  64  second compressed partial sum (already shifted).
- mul_op  input  2  00 MUL.W (low word); 01 MULH.W; 10 MULH.WU (high word); 11 treated as 00.
- mul_tag  input  5  destination register tag; passed through unchanged.
- mul_flush  input  1  kill all in-flight operations.
- mul_out_valid  output  1  result valid.
- mul_out_ready  input  1  consumer accepts result.
- mul_result  output  32  selected product word.
- mul_out_tag  output  5  tag of mul_result.
- mul_cnt  output  32  completed-operation count (only when MUL_STAT_EN is defined).

Function
REQ-003 The block SHALL compute sum = (mul_tmp1 + mul_tmp2) mod 2^64 as a two-stage pipeline, S1 followed by S2.
REQ-004 On accept, S1 SHALL register the low 32-bit sum, its carry-out, the high 32 bits of both operands, op and tag.
REQ-005 On S1-to-S2 advance, S2 SHALL register the low sum and high = tmp1[63:32] + tmp2[63:32] + carry (mod 2^32).
REQ-006 mul_result SHALL be the low word for op 00/11 and the high word for op 01/10, driven from S2 registers only, with no combinational path from the inputs.
REQ-007 The accept condition SHALL be mul_in_valid && mul_in_ready.
REQ-008 Latency from accept to mul_out_valid SHALL be exactly 2 cycles when mul_out_ready is held high.
REQ-009 Throughput SHALL be one operation per cycle with no bubbles under continuous valid/ready.
REQ-010 s2_adv SHALL equal !s2_valid || mul_out_ready, and s1_adv SHALL equal !s1_valid || s2_adv.
REQ-011 mul_in_ready SHALL equal s1_adv and SHALL NOT depend on mul_in_valid.
REQ-012 S2 SHALL hold its data and mul_out_valid stable while mul_out_valid && !mul_out_ready.
REQ-013 When S2 is held, S1 SHALL also hold, and no new input SHALL be accepted while S1 is full.
REQ-014 When S2 drains and S1 refills in the same cycle, both transfers SHALL occur and no operation SHALL be lost or duplicated.
REQ-015 mul_flush SHALL clear s1_valid and s2_valid at the next edge and SHALL take priority over accept and advance.
REQ-016 An input presented in the same cycle as mul_flush SHALL be discarded.
REQ-017 Data registers SHALL NOT need clearing on flush; only the valid bits are cleared.
REQ-018 Overflow of the 64-bit sum SHALL wrap silently and SHALL NOT raise any flag.

Reset
REQ-019 While rstn is 0 at a clock edge, s1_valid, s2_valid and mul_out_valid SHALL be 0, and mul_result, mul_out_tag and mul_cnt SHALL be 0.
REQ-020 mul_in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-021 A reset asserted mid-operation SHALL discard all in-flight operations, with no output produced for them.

Configuration
REQ-022 When the macro MUL_STAT_EN is defined, mul_cnt SHALL increment by 1 on each mul_out_valid && mul_out_ready cycle.
REQ-023 mul_cnt SHALL wrap from 0xFFFF_FFFF to 0.
REQ-024 Flushed operations SHALL NOT be counted.
REQ-025 When MUL_STAT_EN is undefined, the mul_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover: tmp1=15, tmp2=0, op=00, tag=3, out_ready=1 -> exactly 2 cycles later out_valid=1, result=0x0000_000F, out_tag=3.
REQ-027 The bench SHALL cover: tmp1=0x0000_0000_FFFF_FFFF, tmp2=1, op=01 -> result=0x0000_0001 (carry crosses the stage boundary); the same with op=00 -> result=0.
REQ-028 The bench SHALL cover: 4 back-to-back ops with out_ready=0 from cycle 2 -> in_ready falls after 2 accepts; raising out_ready delivers all 4 in order with tags intact.
REQ-029 The bench SHALL cover: mul_flush pulsed with both stages full and a new input valid -> next cycle both valids are 0, nothing is output, and that input is dropped.
REQ-030 The bench SHALL cover: rstn=0 for one cycle with S1 full -> out_valid stays 0, and in_ready=1 the cycle after release.
REQ-031 The bench SHALL cover, with MUL_STAT_EN defined: 5 completed and 2 flushed ops -> mul_cnt=5; and mul_cnt preloaded to 0xFFFF_FFFF plus 1 completion -> 0.
